// File: rtl/store_pkg.sv
// Shared types for the store queue / drain sequencer.
// Size encodings, FSM states and the queued store entry layout.
package store_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] val;
        logic [1:0]  size;
    } store_entry_t;

endpackage

// File: rtl/store_lane_gen.sv
// Byte-lane strobe and replicated write data for a store of a given size.
// Purely combinational, zero latency, no flow control.
module store_lane_gen
    import store_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] val_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    // Size 2'b11 falls through to the word default.
    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = val_i;
        case (size_i)
            SIZE_BYTE: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{val_i[7:0]}};
            end
            SIZE_HALF: begin
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{val_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_drain_ctrl.sv
// In-order store queue draining one entry at a time onto a req/ack write port.
// Push to first mem_req is 2 cycles; back-to-back issue when ack is immediate.
// Pushes while full are dropped and flagged; entries stay queued until acked.
module store_drain_ctrl
    import store_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        store_push,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_val,
    input  logic [1:0]  store_size,
    output logic        storefifo_full,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] load_addr,
    input  logic        load_check,
    output logic        load_conflict,
    output logic        store_empty,
    output logic        overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    store_entry_t     queue_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic             ovf_q, ovf_d;

    logic             push_ok, pop;
    logic [PTR_W-1:0] head_idx, slot_off;
    store_entry_t     head;
    logic [3:0]       head_wstrb;
    logic [31:0]      head_wdata;
    logic             unused_load_lo;

    assign storefifo_full = (count_q == CNT_W'(DEPTH));
    assign store_empty    = (count_q == '0);
    assign mem_req        = (state_q == BUSY);
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign overflow_err   = ovf_q;
    assign unused_load_lo = ^load_addr[1:0];

    assign push_ok = store_push && !storefifo_full;
    assign pop     = (state_q == BUSY) && mem_ack;

    // While busy the slot after the in-flight entry is the one latched on ack.
    assign head_idx = (state_q == BUSY) ? rd_q + PTR_W'(1) : rd_q;
    assign head     = queue_q[head_idx];

    store_lane_gen u_lane_gen (
        .addr_lo_i (head.addr[1:0]),
        .size_i    (head.size),
        .val_i     (head.val),
        .wstrb_o   (head_wstrb),
        .wdata_o   (head_wdata)
    );

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        ovf_d       = ovf_q | (store_push && storefifo_full);
        if (push_ok) begin
            wr_d = wr_q + PTR_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    mem_addr_d  = {head.addr[31:2], 2'b00};
                    mem_wdata_d = head_wdata;
                    mem_wstrb_d = head_wstrb;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    rd_d = rd_q + PTR_W'(1);
                    // A same-cycle push is not counted here, so it waits one IDLE cycle.
                    if (count_q > CNT_W'(1)) begin
                        mem_addr_d  = {head.addr[31:2], 2'b00};
                        mem_wdata_d = head_wdata;
                        mem_wstrb_d = head_wstrb;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            queue_q[wr_q] <= '{addr: store_addr, val: store_val, size: store_size};
        end
    end

    // Occupied slots are those within count_q of the read pointer, in-flight head included.
    always_comb begin
        load_conflict = 1'b0;
        slot_off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_q;
            if (({1'b0, slot_off} < count_q) &&
                (queue_q[i].addr[31:2] == load_addr[31:2])) begin
                load_conflict = 1'b1;
            end
        end
        load_conflict = load_conflict && load_check;
    end

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl with hand-computed expectations.
module tb_store_drain_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        store_push;
    logic [31:0] store_addr;
    logic [31:0] store_val;
    logic [1:0]  store_size;
    logic        storefifo_full;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] load_addr;
    logic        load_check;
    logic        load_conflict;
    logic        store_empty;
    logic        overflow_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] v_addr  [4] = '{32'h0000_2002, 32'h0000_2004, 32'h0000_2009, 32'h0000_2011};
    logic [31:0] v_val   [4] = '{32'h0000_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_5678};
    logic [1:0]  v_size  [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [31:0] e_addr  [4] = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008, 32'h0000_2010};
    logic [3:0]  e_wstrb [4] = '{4'b1100, 4'b1111, 4'b1111, 4'b0011};
    logic [31:0] e_wdata [4] = '{32'h1234_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h5678_5678};

    always #5 clk = ~clk;

    store_drain_ctrl #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .store_push     (store_push),
        .store_addr     (store_addr),
        .store_val      (store_val),
        .store_size     (store_size),
        .storefifo_full (storefifo_full),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ack        (mem_ack),
        .load_addr      (load_addr),
        .load_check     (load_check),
        .load_conflict  (load_conflict),
        .store_empty    (store_empty),
        .overflow_err   (overflow_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
        store_push = 1'b1;
        store_addr = a;
        store_val  = v;
        store_size = s;
        step();
        store_push = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        check(tag, {31'd0, mem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        store_push = 1'b0;
        store_addr = '0;
        store_val  = '0;
        store_size = '0;
        mem_ack    = 1'b0;
        load_addr  = '0;
        load_check = 1'b1;
        step();
        step();
        check("rst_req",   {31'd0, mem_req}, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_full",  {31'd0, storefifo_full}, 32'd0);
        check("rst_empty", {31'd0, store_empty}, 32'd1);
        check("rst_ovf",   {31'd0, overflow_err}, 32'd0);
        check("rst_confl", {31'd0, load_conflict}, 32'd0);
        load_check = 1'b0;
        reset = 1'b0;
        step();

        // Single byte store, ack tied high: request appears exactly two cycles after push.
        mem_ack = 1'b1;
        push(32'h0000_1003, 32'h0000_00AB, 2'd0);
        check("sb_n1_req",   {31'd0, mem_req}, 32'd0);
        check("sb_n1_empty", {31'd0, store_empty}, 32'd0);
        step();
        check("sb_n2_req",   {31'd0, mem_req}, 32'd1);
        check("sb_addr",     mem_addr, 32'h0000_1000);
        check("sb_wstrb",    {28'd0, mem_wstrb}, 32'h8);
        check("sb_wdata",    mem_wdata, 32'hABAB_ABAB);
        check("sb_empty_bz", {31'd0, store_empty}, 32'd0);
        step();
        check("sb_empty",    {31'd0, store_empty}, 32'd1);
        check("sb_req_drop", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;

        // Fill, overflow, then drain back-to-back in push order.
        for (int i = 0; i < 4; i++) begin
            push(32'h0000_0100 + 32'(4 * i), 32'h0000_00A0 + 32'(i), 2'd2);
        end
        check("fill_full", {31'd0, storefifo_full}, 32'd1);
        push(32'h0000_0110, 32'h0000_00FF, 2'd2);
        check("ovf_set",   {31'd0, overflow_err}, 32'd1);
        check("ovf_full",  {31'd0, storefifo_full}, 32'd1);
        wait_req("fill_wait");
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_req", i), {31'd0, mem_req}, 32'd1);
            check($sformatf("drain%0d_addr", i), mem_addr, 32'h0000_0100 + 32'(4 * i));
            check($sformatf("drain%0d_data", i), mem_wdata, 32'h0000_00A0 + 32'(i));
            step();
        end
        mem_ack = 1'b0;
        check("drain_idle",  {31'd0, mem_req}, 32'd0);
        check("drain_empty", {31'd0, store_empty}, 32'd1);

        // Half, word and size-3 lane generation.
        for (int i = 0; i < 4; i++) begin
            push(v_addr[i], v_val[i], v_size[i]);
        end
        wait_req("lane_wait");
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lane%0d_addr", i), mem_addr, e_addr[i]);
            check($sformatf("lane%0d_strb", i), {28'd0, mem_wstrb}, {28'd0, e_wstrb[i]});
            check($sformatf("lane%0d_data", i), mem_wdata, e_wdata[i]);
            step();
        end
        mem_ack = 1'b0;
        check("lane_empty", {31'd0, store_empty}, 32'd1);

        // Word-granular load conflict against in-flight head and a queued entry.
        push(32'h0000_3008, 32'h1111_1111, 2'd2);
        push(32'h0000_4000, 32'h2222_2222, 2'd2);
        load_check = 1'b1;
        load_addr = 32'h0000_300B; #1;
        check("confl_same_word", {31'd0, load_conflict}, 32'd1);
        load_addr = 32'h0000_300C; #1;
        check("confl_next_word", {31'd0, load_conflict}, 32'd0);
        load_addr = 32'h0000_4003; #1;
        check("confl_second", {31'd0, load_conflict}, 32'd1);
        load_check = 1'b0; #1;
        check("confl_nocheck", {31'd0, load_conflict}, 32'd0);
        wait_req("confl_wait");
        mem_ack = 1'b1;
        step();
        step();
        mem_ack = 1'b0;
        load_check = 1'b1;
        load_addr = 32'h0000_300B; #1;
        check("confl_after_ack", {31'd0, load_conflict}, 32'd0);
        load_check = 1'b0;

        // Steady push+ack with two entries resident; pointers wrap several times.
        push(32'h0000_5000, 32'd0, 2'd2);
        push(32'h0000_5004, 32'd1, 2'd2);
        wait_req("wrap_wait");
        mem_ack = 1'b1;
        for (int j = 0; j < 10; j++) begin
            store_push = 1'b1;
            store_addr = 32'h0000_5000 + 32'(4 * (j + 2));
            store_val  = 32'(j + 2);
            store_size = 2'd2;
            load_check = 1'b1;
            load_addr  = 32'h0000_5000 + 32'(4 * (j + 1)); #1;
            check($sformatf("wrap%0d_confl_q", j), {31'd0, load_conflict}, 32'd1);
            load_addr  = 32'h0000_5000 + 32'(4 * (j + 2)); #1;
            check($sformatf("wrap%0d_confl_p", j), {31'd0, load_conflict}, 32'd0);
            load_check = 1'b0;
            check($sformatf("wrap%0d_addr", j), mem_addr, 32'h0000_5000 + 32'(4 * j));
            check($sformatf("wrap%0d_full", j), {31'd0, storefifo_full}, 32'd0);
            step();
        end
        store_push = 1'b0;
        check("wrap_tail0", mem_addr, 32'h0000_5028);
        step();
        check("wrap_tail1", mem_addr, 32'h0000_502C);
        step();
        mem_ack = 1'b0;
        check("wrap_idle", {31'd0, mem_req}, 32'd0);
        check("wrap_empty", {31'd0, store_empty}, 32'd1);

        // Asynchronous reset while a request is outstanding with three queued.
        check("ovf_sticky", {31'd0, overflow_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            push(32'h0000_6000 + 32'(4 * i), 32'(i), 2'd2);
        end
        wait_req("arst_wait");
        reset = 1'b1; #1;
        check("arst_req",   {31'd0, mem_req}, 32'd0);
        check("arst_empty", {31'd0, store_empty}, 32'd1);
        check("arst_ovf",   {31'd0, overflow_err}, 32'd0);
        step();
        reset = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst%0d_req", i), {31'd0, mem_req}, 32'd0);
        end
        check("post_rst_empty", {31'd0, store_empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
